// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between N requesters and the round-robin arbiter.
interface rr_arbiter_if #(
    parameter int unsigned N = 4
) ();
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  req;
    logic [N-1:0]  grant;
    logic          busy;
    logic [IW-1:0] owner;
    logic          timeout;

    // Requester side drives req and observes the arbitration result.
    modport master (
        output req,
        input  grant,
        input  busy,
        input  owner,
        input  timeout
    );

    // Arbiter side samples req and drives the registered result.
    modport slave (
        input  req,
        output grant,
        output busy,
        output owner,
        output timeout
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant hold until release and a hold-limit watchdog.
module rr_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic        clk,
    input  logic        rstn,
    rr_arbiter_if.slave bus
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  grant_q, grant_d;
    logic          busy_q, busy_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    logic          found_c;
    logic [IW-1:0] win_c;

    // Cyclic search for the first pending request starting just after ptr_q.
    always_comb begin
        logic [IW-1:0] cand;
        found_c = 1'b0;
        win_c   = '0;
        cand    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = IW'((32'(ptr_q) + i) % N);
            if (!found_c && bus.req[cand]) begin
                found_c = 1'b1;
                win_c   = cand;
            end
        end
    end

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d = BUSY;
                    grant_d = N'(1) << win_c;
                    owner_d = win_c;
                    ptr_d   = win_c;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                // Release wins over a coincident hold-limit expiry.
                if (!bus.req[owner_q]) begin
                    state_d = IDLE;
                    grant_d = '0;
                end else if ((MAX_HOLD != 0) && (cnt_q == CW'(MAX_HOLD - 1))) begin
                    state_d   = IDLE;
                    grant_d   = '0;
                    timeout_d = 1'b1;
                end else if (cnt_q != {CW{1'b1}}) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase

        busy_d = |grant_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            owner_q   <= '0;
            ptr_q     <= IW'(N - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.owner   = owner_q;
    assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: three instances with hold limits 16, 4 and 2.
module tb_rr_arbiter;
    logic clk = 1'b0;
    logic rstn_a, rstn_b, rstn_c;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    rr_arbiter_if #(.N(4)) if_a ();
    rr_arbiter_if #(.N(4)) if_b ();
    rr_arbiter_if #(.N(4)) if_c ();

    rr_arbiter #(.N(4), .MAX_HOLD(16)) u_a (.clk(clk), .rstn(rstn_a), .bus(if_a.slave));
    rr_arbiter #(.N(4), .MAX_HOLD(4))  u_b (.clk(clk), .rstn(rstn_b), .bus(if_b.slave));
    rr_arbiter #(.N(4), .MAX_HOLD(2))  u_c (.clk(clk), .rstn(rstn_c), .bus(if_c.slave));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Runaway guard so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn_a = 1'b0; rstn_b = 1'b0; rstn_c = 1'b0;
        if_a.req = '0; if_b.req = '0; if_c.req = '0;
        tick(); tick();

        // Reset state
        chk("rst_grant",   16'(if_a.grant),   16'h0);
        chk("rst_busy",    16'(if_a.busy),    16'h0);
        chk("rst_owner",   16'(if_a.owner),   16'h0);
        chk("rst_timeout", 16'(if_a.timeout), 16'h0);
        chk("rst_grant_b", 16'(if_b.grant),   16'h0);
        chk("rst_grant_c", 16'(if_c.grant),   16'h0);
        rstn_a = 1'b1; rstn_b = 1'b1; rstn_c = 1'b1;
        tick();
        chk("idle_no_req", 16'(if_a.grant), 16'h0);

        // Single request: granted one edge after sampling, held 4 cycles, released
        if_a.req = 4'b0010;
        tick();
        chk("single_grant", 16'(if_a.grant), 16'h2);
        chk("single_owner", 16'(if_a.owner), 16'h1);
        chk("single_busy",  16'(if_a.busy),  16'h1);
        tick(); tick(); tick();
        chk("single_hold",  16'(if_a.grant), 16'h2);
        if_a.req = 4'b0000;
        tick();
        chk("single_rel_grant", 16'(if_a.grant),   16'h0);
        chk("single_rel_busy",  16'(if_a.busy),    16'h0);
        chk("single_rel_to",    16'(if_a.timeout), 16'h0);
        chk("single_rel_owner", 16'(if_a.owner),   16'h1);

        // Request withdrawn before it is sampled is never granted
        if_a.req = 4'b0001;
        #2;
        if_a.req = 4'b0000;
        tick();
        chk("unsampled_req", 16'(if_a.grant), 16'h0);

        // Rotation from reset priority: 0,1,2,3,0 with a one-cycle gap
        rstn_a = 1'b0;
        tick();
        rstn_a = 1'b1;
        if_a.req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            logic [3:0] exp_g;
            exp_g = 4'b0001 << (k % 4);
            tick();
            chk("rot_grant", 16'(if_a.grant), 16'(exp_g));
            tick();
            chk("rot_hold", 16'(if_a.grant), 16'(exp_g));
            if_a.req = 4'b1111 & ~exp_g;
            tick();
            chk("rot_gap", 16'(if_a.grant), 16'h0);
            chk("rot_gap_to", 16'(if_a.timeout), 16'h0);
            if_a.req = 4'b1111;
        end

        // Reset mid-grant: outputs clear, then requester 0 wins
        if_a.req = 4'b1000;
        tick();
        chk("mid_pre_grant", 16'(if_a.grant), 16'h8);
        if_a.req = 4'b1001;
        rstn_a = 1'b0;
        tick();
        chk("mid_rst_grant", 16'(if_a.grant),   16'h0);
        chk("mid_rst_busy",  16'(if_a.busy),    16'h0);
        chk("mid_rst_owner", 16'(if_a.owner),   16'h0);
        chk("mid_rst_to",    16'(if_a.timeout), 16'h0);
        rstn_a = 1'b1;
        tick();
        chk("mid_after_grant", 16'(if_a.grant), 16'h1);
        chk("mid_after_owner", 16'(if_a.owner), 16'h0);

        // Timeout with MAX_HOLD=4, second requester raised during the grant
        if_b.req = 4'b0001;
        tick();
        chk("to_grant1", 16'(if_b.grant), 16'h1);
        if_b.req = 4'b0101;
        tick(); tick(); tick();
        chk("to_grant4", 16'(if_b.grant),   16'h1);
        chk("to_nopulse", 16'(if_b.timeout), 16'h0);
        tick();
        chk("to_drop_grant", 16'(if_b.grant),   16'h0);
        chk("to_pulse",      16'(if_b.timeout), 16'h1);
        chk("to_owner",      16'(if_b.owner),   16'h0);
        tick();
        chk("to_next_grant", 16'(if_b.grant),   16'h4);
        chk("to_pulse_end",  16'(if_b.timeout), 16'h0);
        chk("to_next_owner", 16'(if_b.owner),   16'h2);

        // Release coinciding with the hold limit: no timeout pulse
        tick(); tick(); tick();
        chk("co_grant4", 16'(if_b.grant), 16'h4);
        if_b.req = 4'b0000;
        tick();
        chk("co_grant", 16'(if_b.grant),   16'h0);
        chk("co_to",    16'(if_b.timeout), 16'h0);
        tick();
        chk("co_to_after", 16'(if_b.timeout), 16'h0);

        // Sole requester repeatedly re-granted after each timeout (MAX_HOLD=2)
        if_c.req = 4'b0100;
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("sole_g1", 16'(if_c.grant),   16'h4);
            chk("sole_t1", 16'(if_c.timeout), 16'h0);
            tick();
            chk("sole_g2", 16'(if_c.grant),   16'h4);
            tick();
            chk("sole_gap",   16'(if_c.grant),   16'h0);
            chk("sole_pulse", 16'(if_c.timeout), 16'h1);
            chk("sole_owner", 16'(if_c.owner),   16'h2);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter with grant hold and watchdog timeout. Shares one FSM-controlled resource between `N` requesters. Grants one requester at a time and holds the grant until that requester releases it or a hold limit expires. It sits in front of the shared state machine and is the only block that decides which requester drives it in a given cycle.

## Interface
- `N`, default 4: number of requesters, legal range 2..16.
- `MAX_HOLD`, default 16: maximum consecutive grant cycles per ownership. 0 disables the timeout.
- `IW`, default `$clog2(N)`: width of the owner index (derived, not overridden).

Ports:
- `clk`  input  1: clock. All logic is on the rising edge.
- `rstn`  input  1: synchronous active-low reset. Sampled on `posedge clk`.
- `req`  input  N: request lines, level-sensitive. Bit k is held high for as long as requester k wants or uses the resource.
- `grant`  output  N: one-hot or zero grant vector, registered.
- `busy`  output  1: high whenever `grant` is non-zero.
- `owner`  output  IW: index of the current or last granted requester.
- `timeout`  output  1: one-cycle pulse when a grant is force-released.

## Operation
- Reset (`rstn`=0 at an edge) clears outputs and state:
  - `grant`=0, `busy`=0, `owner`=0, `timeout`=0.
  - State goes to IDLE, hold counter to 0, priority pointer `ptr` to N-1, so requester 0 has highest priority after reset.
  - Reset overrides every other event, including a live grant.
- State machine has two states, IDLE and BUSY.
- IDLE:
  - If `req` is zero, stay in IDLE.
  - Otherwise the winner is the first set bit of `req` searching cyclically from `ptr+1`, wrapping past N-1 to 0.
  - On the edge: state goes to BUSY, `grant[winner]`=1, `owner`=winner, `ptr`=winner, counter=0.
- BUSY with owner k:
  - Release: if `req[k]`=0 at the edge, `grant`=0 and state goes to IDLE. No pulse.
  - Timeout: else if `MAX_HOLD`≠0 and counter = MAX_HOLD-1, `grant`=0, `timeout`=1 for the next cycle, state goes to IDLE.
  - Otherwise counter increments and the grant is held.
  - Changes on other `req` bits are ignored while in BUSY.
- If release and the timeout limit coincide, it is a normal release and no `timeout` pulse is issued.
- After a timeout, `ptr`=k, so a different pending requester wins next. Requester k is re-granted only if it is the sole requester.
- Counter width is `$clog2(MAX_HOLD+1)`. It never wraps, because it resets on every grant.
- `owner` holds its value through IDLE. It is valid for attribution of `timeout`.
- `grant` is never multi-hot. `busy` equals the OR-reduction of `grant`, registered in the same cycle.

## Timing
- Request to grant: 1 cycle. `req` is sampled high at edge e while IDLE, and `grant` is high after e.
- Handover takes a one-cycle gap:
  - Owner drops `req` before edge e, and `grant` goes low after e.
  - The next winner is sampled at e+1 and granted after e+1.
  - Minimum time between two different grants is 2 cycles.
- Maximum hold: `grant` is high for exactly MAX_HOLD cycles on timeout. `timeout` is high in the first cycle `grant` is low.
- A request dropped before it is sampled in IDLE is never granted. No request state is latched.
- Reset mid-grant: `grant` is low in the cycle after the reset edge. Arbitration restarts from requester 0 priority.

## Test plan
- Single request:
  - Stimulus: N=4. `req`=0010 at cycle 2, dropped at cycle 6.
  - Response: `grant`=0010 for cycles 3-6, `owner`=1, `grant`=0 at cycle 7, `timeout` never set.
- Rotation:
  - Stimulus: `req`=1111 held, each owner drops its bit for one cycle after 2 granted cycles, then reasserts.
  - Response: grant order 0,1,2,3,0, with a one-cycle zero-grant gap between each.
- Timeout:
  - Stimulus: MAX_HOLD=4, `req`=0001 held forever, plus `req[2]` raised during the grant.
  - Response: `grant`=0001 for 4 cycles, then `grant`=0 with `timeout`=1 and `owner`=0, then `grant`=0100.
- Coincident release and limit:
  - Stimulus: MAX_HOLD=4, owner drops `req` in the 4th granted cycle.
  - Response: `grant`=0 and `timeout`=0.
- Reset mid-grant:
  - Stimulus: `rstn`=0 for 1 cycle while `grant`=1000, with `req`=1001 held.
  - Response: all outputs 0 after the reset edge, then `grant`=0001 two cycles after reset (priority to 0).
- Sole requester after timeout:
  - Stimulus: MAX_HOLD=2, `req`=0100 held.
  - Response: `grant` pattern 0100,0100,0000,0100,0100,0000…, with `timeout` high in each zero cycle.
